// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage data-memory access sequencer with split addr_ok/data_ok bus handshake
module mem_access_ctrl #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic [2:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic              flush,
   output logic              req_ready,
   output logic              stall,
   output logic              data_req,
   output logic              data_wr,
   output logic [1:0]        data_size,
   output logic [ADDR_W-1:0] data_addr,
   output logic [3:0]        data_wstrb,
   output logic [31:0]       data_wdata,
   input  logic              data_addr_ok,
   input  logic              data_data_ok,
   input  logic [31:0]       data_rdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              adel,
   output logic              ades
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

   localparam logic [2:0] OP_LW  = 3'b000;
   localparam logic [2:0] OP_LH  = 3'b001;
   localparam logic [2:0] OP_LHU = 3'b010;
   localparam logic [2:0] OP_LB  = 3'b011;
   localparam logic [2:0] OP_LBU = 3'b100;
   localparam logic [2:0] OP_SW  = 3'b101;
   localparam logic [2:0] OP_SH  = 3'b110;
   localparam logic [2:0] OP_SB  = 3'b111;

   // Access size encoding shared with the bus: 0 byte, 1 half, 2 word.
   function automatic logic [1:0] op_size(input logic [2:0] op);
      case (op)
         OP_LW, OP_SW:         op_size = 2'd2;
         OP_LH, OP_LHU, OP_SH: op_size = 2'd1;
         default:              op_size = 2'd0;
      endcase
   endfunction

   function automatic logic op_is_store(input logic [2:0] op);
      op_is_store = (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
   endfunction

   state_t            state_q, state_d;
   logic [2:0]        op_q, op_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              killed_q, killed_d;
   logic              adel_q, adel_d;
   logic              ades_q, ades_d;
   logic [31:0]       rdata_q, rdata_d;

   logic        req_store;
   logic        req_mis;
   logic [1:0]  req_size;
   logic        cur_store;
   logic [1:0]  cur_size;
   logic [3:0]  fmt_wstrb;
   logic [31:0] fmt_wdata;
   logic [31:0] load_ext;
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;
   logic        in_req;
   logic        capture;

   // Classify the incoming request: store vs load and alignment by access size.
   always_comb begin
      req_store = op_is_store(req_op);
      req_size  = op_size(req_op);
      req_mis   = 1'b0;
      case (req_size)
         2'd2:    req_mis = (req_addr[1:0] != 2'b00);
         2'd1:    req_mis = req_addr[0];
         default: req_mis = 1'b0;
      endcase
   end

   // Byte strobes and lane-replicated write data from the latched store.
   always_comb begin
      cur_store = op_is_store(op_q);
      cur_size  = op_size(op_q);
      fmt_wstrb = 4'b0000;
      fmt_wdata = 32'h0;
      if (cur_store) begin
         case (cur_size)
            2'd2: begin
               fmt_wstrb = 4'b1111;
               fmt_wdata = wdata_q;
            end
            2'd1: begin
               fmt_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
               fmt_wdata = {2{wdata_q[15:0]}};
            end
            default: begin
               fmt_wstrb = 4'b0001 << addr_q[1:0];
               fmt_wdata = {4{wdata_q[7:0]}};
            end
         endcase
      end
   end

   // Lane select and sign/zero extension of the returned read word.
   always_comb begin
      case (addr_q[1:0])
         2'd0:    rd_byte = data_rdata[7:0];
         2'd1:    rd_byte = data_rdata[15:8];
         2'd2:    rd_byte = data_rdata[23:16];
         default: rd_byte = data_rdata[31:24];
      endcase
      rd_half = addr_q[1] ? data_rdata[31:16] : data_rdata[15:0];
      case (op_q)
         OP_LW:   load_ext = data_rdata;
         OP_LH:   load_ext = {{16{rd_half[15]}}, rd_half};
         OP_LHU:  load_ext = {16'h0, rd_half};
         OP_LB:   load_ext = {{24{rd_byte[7]}}, rd_byte};
         OP_LBU:  load_ext = {24'h0, rd_byte};
         default: load_ext = 32'h0;
      endcase
   end

   // Next-state, handshake and pipeline-control outputs.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      killed_d  = killed_q;
      adel_d    = 1'b0;
      ades_d    = 1'b0;
      rdata_d   = rdata_q;
      req_ready = 1'b0;
      stall     = 1'b0;
      data_req  = 1'b0;
      capture   = 1'b0;
      case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid && !flush) begin
               if (req_mis) begin
                  adel_d = !req_store;
                  ades_d = req_store;
               end else begin
                  stall   = 1'b1;
                  op_d    = req_op;
                  addr_d  = req_addr;
                  wdata_d = req_wdata;
                  state_d = S_REQ;
               end
            end
         end
         S_REQ: begin
            data_req = 1'b1;
            stall    = 1'b1;
            if (data_addr_ok) begin
               // Once the address is taken the bus must finish; a flush only kills the response.
               if (flush) killed_d = 1'b1;
               if (data_data_ok) begin
                  capture = 1'b1;
                  state_d = S_DONE;
               end else begin
                  state_d = S_WAIT;
               end
            end else if (flush) begin
               state_d = S_IDLE;
            end
         end
         S_WAIT: begin
            stall = 1'b1;
            if (flush) killed_d = 1'b1;
            if (data_data_ok) begin
               capture = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d  = S_IDLE;
            killed_d = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase
      // Killed ops leave the previous response data untouched.
      if (capture && !(killed_q || flush)) begin
         rdata_d = cur_store ? 32'h0 : load_ext;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         op_q     <= 3'b000;
         addr_q   <= '0;
         wdata_q  <= 32'h0;
         killed_q <= 1'b0;
         adel_q   <= 1'b0;
         ades_q   <= 1'b0;
         rdata_q  <= 32'h0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         killed_q <= killed_d;
         adel_q   <= adel_d;
         ades_q   <= ades_d;
         rdata_q  <= rdata_d;
      end
   end

   // Bus outputs are only non-zero while the request is being presented.
   always_comb begin
      in_req     = (state_q == S_REQ);
      data_wr    = in_req & cur_store;
      data_size  = in_req ? cur_size : 2'd0;
      data_addr  = in_req ? addr_q : '0;
      data_wstrb = in_req ? fmt_wstrb : 4'b0000;
      data_wdata = in_req ? fmt_wdata : 32'h0;
      resp_valid = (state_q == S_DONE) && !killed_q;
      resp_rdata = rdata_q;
      adel       = adel_q;
      ades       = ades_q;
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed vector bench for mem_access_ctrl
module tb_mem_access_ctrl;

   localparam logic [2:0] OP_LW  = 3'b000;
   localparam logic [2:0] OP_LH  = 3'b001;
   localparam logic [2:0] OP_LHU = 3'b010;
   localparam logic [2:0] OP_LB  = 3'b011;
   localparam logic [2:0] OP_LBU = 3'b100;
   localparam logic [2:0] OP_SW  = 3'b101;
   localparam logic [2:0] OP_SH  = 3'b110;
   localparam logic [2:0] OP_SB  = 3'b111;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic [2:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        flush;
   logic        req_ready;
   logic        stall;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [3:0]  data_wstrb;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        adel;
   logic        ades;

   int tests;
   int fails;

   mem_access_ctrl #(.ADDR_W(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
      .flush(flush), .req_ready(req_ready), .stall(stall),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
      .data_wstrb(data_wstrb), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .adel(adel), .ades(ades)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        exp_adel;
      logic        exp_ades;
      logic [1:0]  exp_size;
      logic        exp_wr;
      logic [3:0]  exp_wstrb;
      logic [31:0] exp_wdata;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      string p;
      p = $sformatf("v%0d", idx);
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = v.op;
      req_addr  = v.addr;
      req_wdata = v.wdata;
      #1;
      chk({p, " req_ready"}, {31'h0, req_ready}, 32'd1);
      chk({p, " accept stall"}, {31'h0, stall}, {31'h0, !(v.exp_adel || v.exp_ades)});
      if (v.exp_adel || v.exp_ades) begin
         @(negedge clk);
         req_valid = 1'b0;
         #1;
         chk({p, " adel"}, {31'h0, adel}, {31'h0, v.exp_adel});
         chk({p, " ades"}, {31'h0, ades}, {31'h0, v.exp_ades});
         chk({p, " no data_req"}, {31'h0, data_req}, 32'd0);
         chk({p, " no stall"}, {31'h0, stall}, 32'd0);
         chk({p, " no resp"}, {31'h0, resp_valid}, 32'd0);
         @(negedge clk);
         chk({p, " adel drop"}, {31'h0, adel}, 32'd0);
         chk({p, " ades drop"}, {31'h0, ades}, 32'd0);
         chk({p, " still no data_req"}, {31'h0, data_req}, 32'd0);
      end else begin
         @(negedge clk);
         req_valid = 1'b0;
         #1;
         chk({p, " data_req"}, {31'h0, data_req}, 32'd1);
         chk({p, " data_wr"}, {31'h0, data_wr}, {31'h0, v.exp_wr});
         chk({p, " data_size"}, {30'h0, data_size}, {30'h0, v.exp_size});
         chk({p, " data_addr"}, data_addr, v.addr);
         chk({p, " data_wstrb"}, {28'h0, data_wstrb}, {28'h0, v.exp_wstrb});
         chk({p, " data_wdata"}, data_wdata, v.exp_wdata);
         chk({p, " req stall"}, {31'h0, stall}, 32'd1);
         data_addr_ok = 1'b1;
         data_data_ok = 1'b1;
         data_rdata   = v.rdata;
         @(negedge clk);
         data_addr_ok = 1'b0;
         data_data_ok = 1'b0;
         #1;
         chk({p, " resp_valid"}, {31'h0, resp_valid}, 32'd1);
         chk({p, " resp_rdata"}, resp_rdata, v.exp_rdata);
         chk({p, " done stall"}, {31'h0, stall}, 32'd0);
         chk({p, " done data_req"}, {31'h0, data_req}, 32'd0);
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst = 1'b1;
      req_valid = 1'b0; req_op = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
      flush = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;

      //           op      addr          wdata         rdata         adel  ades  size  wr    wstrb    exp_wdata     exp_rdata
      vecs[0]  = '{OP_LB,  32'h0000_1003, 32'h0,        32'h80FF_0000, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 32'h0,        32'hFFFF_FF80};
      vecs[1]  = '{OP_LBU, 32'h0000_1003, 32'h0,        32'h80FF_0000, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 32'h0,        32'h0000_0080};
      vecs[2]  = '{OP_SH,  32'h0000_2002, 32'h1234_ABCD, 32'hFFFF_FFFF, 1'b0, 1'b0, 2'd1, 1'b1, 4'b1100, 32'hABCD_ABCD, 32'h0};
      vecs[3]  = '{OP_SB,  32'h0000_2001, 32'h0000_0055, 32'h0,        1'b0, 1'b0, 2'd0, 1'b1, 4'b0010, 32'h5555_5555, 32'h0};
      vecs[4]  = '{OP_LW,  32'h0000_1001, 32'h0,        32'h0,        1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 32'h0,        32'h0};
      vecs[5]  = '{OP_SH,  32'h0000_2003, 32'h0,        32'h0,        1'b0, 1'b1, 2'd0, 1'b0, 4'b0000, 32'h0,        32'h0};
      vecs[6]  = '{OP_LH,  32'h0000_1002, 32'h0,        32'h8001_7FFF, 1'b0, 1'b0, 2'd1, 1'b0, 4'b0000, 32'h0,        32'hFFFF_8001};
      vecs[7]  = '{OP_LHU, 32'h0000_1000, 32'h0,        32'h8001_F00F, 1'b0, 1'b0, 2'd1, 1'b0, 4'b0000, 32'h0,        32'h0000_F00F};
      vecs[8]  = '{OP_LW,  32'h0000_1004, 32'h0,        32'hDEAD_BEEF, 1'b0, 1'b0, 2'd2, 1'b0, 4'b0000, 32'h0,        32'hDEAD_BEEF};
      vecs[9]  = '{OP_SW,  32'h0000_3000, 32'hCAFE_F00D, 32'h0,        1'b0, 1'b0, 2'd2, 1'b1, 4'b1111, 32'hCAFE_F00D, 32'h0};
      vecs[10] = '{OP_LB,  32'h0000_1000, 32'h0,        32'h0000_007F, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 32'h0,        32'h0000_007F};
      vecs[11] = '{OP_SB,  32'h0000_2003, 32'h0000_00AB, 32'h0,        1'b0, 1'b0, 2'd0, 1'b1, 4'b1000, 32'hABAB_ABAB, 32'h0};
      vecs[12] = '{OP_LH,  32'h0000_1001, 32'h0,        32'h0,        1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 32'h0,        32'h0};
      vecs[13] = '{OP_SW,  32'h0000_3002, 32'h0,        32'h0,        1'b0, 1'b1, 2'd0, 1'b0, 4'b0000, 32'h0,        32'h0};
      vecs[14] = '{OP_LB,  32'h0000_1001, 32'h0,        32'h1234_5678, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 32'h0,        32'h0000_0056};

      #2;
      chk("rst req_ready", {31'h0, req_ready}, 32'd1);
      chk("rst stall", {31'h0, stall}, 32'd0);
      chk("rst data_req", {31'h0, data_req}, 32'd0);
      chk("rst resp_valid", {31'h0, resp_valid}, 32'd0);
      chk("rst resp_rdata", resp_rdata, 32'h0);
      chk("rst adel", {31'h0, adel}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

      // Delayed addr_ok (3 cycles) then data_ok 2 cycles later on a store.
      @(negedge clk);
      req_valid = 1'b1; req_op = OP_SW; req_addr = 32'h0000_3004; req_wdata = 32'h1122_3344;
      #1;
      chk("slow accept stall", {31'h0, stall}, 32'd1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         req_valid = 1'b0;
         data_addr_ok = (k == 3);
         #1;
         chk($sformatf("slow k%0d data_req", k), {31'h0, data_req}, 32'd1);
         chk($sformatf("slow k%0d data_addr", k), data_addr, 32'h0000_3004);
         chk($sformatf("slow k%0d data_wstrb", k), {28'h0, data_wstrb}, 32'hF);
         chk($sformatf("slow k%0d data_wdata", k), data_wdata, 32'h1122_3344);
         chk($sformatf("slow k%0d stall", k), {31'h0, stall}, 32'd1);
      end
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         data_addr_ok = 1'b0;
         #1;
         chk($sformatf("slow wait%0d data_req", k), {31'h0, data_req}, 32'd0);
         chk($sformatf("slow wait%0d stall", k), {31'h0, stall}, 32'd1);
         chk($sformatf("slow wait%0d resp_valid", k), {31'h0, resp_valid}, 32'd0);
      end
      data_data_ok = 1'b1;
      @(negedge clk);
      data_data_ok = 1'b0;
      #1;
      chk("slow resp_valid", {31'h0, resp_valid}, 32'd1);
      chk("slow resp_rdata", resp_rdata, 32'h0);
      chk("slow done stall", {31'h0, stall}, 32'd0);
      @(negedge clk);
      chk("slow resp once", {31'h0, resp_valid}, 32'd0);

      // Flush in REQ before addr_ok aborts without a response.
      @(negedge clk);
      req_valid = 1'b1; req_op = OP_LW; req_addr = 32'h0000_1008;
      @(negedge clk);
      req_valid = 1'b0; flush = 1'b1;
      #1;
      chk("freq data_req", {31'h0, data_req}, 32'd1);
      @(negedge clk);
      flush = 1'b0;
      #1;
      chk("freq req_ready", {31'h0, req_ready}, 32'd1);
      chk("freq data_req off", {31'h0, data_req}, 32'd0);
      chk("freq stall", {31'h0, stall}, 32'd0);
      chk("freq resp_valid", {31'h0, resp_valid}, 32'd0);
      @(negedge clk);
      chk("freq resp_valid later", {31'h0, resp_valid}, 32'd0);

      // Flush in WAIT: stall holds until data_ok, response suppressed.
      @(negedge clk);
      req_valid = 1'b1; req_op = OP_LW; req_addr = 32'h0000_100C;
      @(negedge clk);
      req_valid = 1'b0; data_addr_ok = 1'b1;
      @(negedge clk);
      data_addr_ok = 1'b0; flush = 1'b1;
      #1;
      chk("fwait stall flush", {31'h0, stall}, 32'd1);
      @(negedge clk);
      flush = 1'b0;
      #1;
      chk("fwait stall held", {31'h0, stall}, 32'd1);
      chk("fwait resp_valid", {31'h0, resp_valid}, 32'd0);
      chk("fwait data_req", {31'h0, data_req}, 32'd0);
      data_data_ok = 1'b1; data_rdata = 32'h0000_0099;
      @(negedge clk);
      data_data_ok = 1'b0;
      #1;
      chk("fwait done resp_valid", {31'h0, resp_valid}, 32'd0);
      chk("fwait done stall", {31'h0, stall}, 32'd0);
      chk("fwait resp_rdata held", resp_rdata, 32'h0);
      run_vec(100, vecs[1]);

      // Reset in the middle of WAIT, then a stale data_ok.
      @(negedge clk);
      req_valid = 1'b1; req_op = OP_LW; req_addr = 32'h0000_1010;
      @(negedge clk);
      req_valid = 1'b0; data_addr_ok = 1'b1;
      @(negedge clk);
      data_addr_ok = 1'b0;
      #1;
      chk("rwait stall", {31'h0, stall}, 32'd1);
      rst = 1'b1;
      #1;
      chk("rwait req_ready", {31'h0, req_ready}, 32'd1);
      chk("rwait stall off", {31'h0, stall}, 32'd0);
      chk("rwait data_req", {31'h0, data_req}, 32'd0);
      chk("rwait resp_valid", {31'h0, resp_valid}, 32'd0);
      chk("rwait resp_rdata", resp_rdata, 32'h0);
      @(negedge clk);
      rst = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      data_data_ok = 1'b0;
      #1;
      chk("stale resp_valid", {31'h0, resp_valid}, 32'd0);
      chk("stale req_ready", {31'h0, req_ready}, 32'd1);
      @(negedge clk);
      chk("stale resp_valid later", {31'h0, resp_valid}, 32'd0);
      run_vec(101, vecs[8]);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
